// File: rtl/bbox_extract.sv
// rtl/bbox_extract.sv - per-frame bounding-box extractor for the face-detection overlay
//
// Tracks the min/max column and row of asserted mask pixels over a raster frame.
// At end of frame it publishes the box center and extent, together with a flag
// saying whether enough pixels were seen.
//
// Optional feature: define BBOX_SMOOTH_EN to enable temporal smoothing of the
// reported x/y/width/height across consecutive found frames.
//
// Parameters:
//   IMG_WIDTH   pixels per line
//   IMG_HEIGHT  lines per frame
//   MIN_PIXELS  minimum asserted-pixel count for a frame to count as a detection
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   wr_en       pixel valid; mask sampled and raster advanced only when high
//   mask        detection flag for the current pixel
//   x, y        box center column / row
//   width       box horizontal extent (max_x - min_x)
//   height      box vertical extent (max_y - min_y)
//   found       last completed frame met MIN_PIXELS
//   bbox_valid  one-cycle pulse when the outputs update

module bbox_extract #(
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576,
  parameter int MIN_PIXELS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       mask,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] width,
  output logic [9:0] height,
  output logic       found,
  output logic       bbox_valid
);

  localparam logic [9:0]  X_LAST  = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]  Y_LAST  = 10'(IMG_HEIGHT - 1);
  localparam logic [9:0]  MIN_INIT = 10'h3FF;
  localparam logic [19:0] CNT_MAX = 20'hF_FFFF;
  localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

  // Raster position and per-frame accumulators
  logic [9:0]  x_cnt, y_cnt;
  logic [9:0]  min_x, max_x, min_y, max_y;
  logic [19:0] cnt;

  // Accumulators with the current pixel merged in; used both for the running
  // update and for evaluation at end of frame, so the EOF pixel is included.
  logic        hit;
  logic        eof;
  logic [9:0]  mn_x, mx_x, mn_y, mx_y;
  logic [19:0] c_merged;
  logic        frame_found;

  // Raw per-frame results
  logic [10:0] sum_x, sum_y;
  logic [9:0]  new_x, new_y, new_w, new_h;

  always_comb begin
    hit = wr_en && mask;
    eof = wr_en && (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    mn_x     = min_x;
    mx_x     = max_x;
    mn_y     = min_y;
    mx_y     = max_y;
    c_merged = cnt;
    if (hit) begin
      if (x_cnt < min_x) mn_x = x_cnt;
      if (x_cnt > max_x) mx_x = x_cnt;
      if (y_cnt < min_y) mn_y = y_cnt;
      if (y_cnt > max_y) mx_y = y_cnt;
      if (cnt != CNT_MAX) c_merged = cnt + 20'd1;
    end

    frame_found = (c_merged >= MIN_CNT);

    sum_x = {1'b0, mn_x} + {1'b0, mx_x};
    sum_y = {1'b0, mn_y} + {1'b0, mx_y};
    new_x = sum_x[10:1];
    new_y = sum_y[10:1];
    // Only meaningful when frame_found; otherwise the values are discarded.
    new_w = mx_x - mn_x;
    new_h = mx_y - mn_y;
  end

`ifdef BBOX_SMOOTH_EN
  // history: the previously reported values came from a found frame that is
  // still part of an unbroken run, so the new frame is averaged with them.
  logic        history;
  logic [10:0] avg_x, avg_y, avg_w, avg_h;
  logic [9:0]  pub_x, pub_y, pub_w, pub_h;

  always_comb begin
    avg_x = {1'b0, x}      + {1'b0, new_x};
    avg_y = {1'b0, y}      + {1'b0, new_y};
    avg_w = {1'b0, width}  + {1'b0, new_w};
    avg_h = {1'b0, height} + {1'b0, new_h};
    if (history) begin
      pub_x = avg_x[10:1];
      pub_y = avg_y[10:1];
      pub_w = avg_w[10:1];
      pub_h = avg_h[10:1];
    end else begin
      pub_x = new_x;
      pub_y = new_y;
      pub_w = new_w;
      pub_h = new_h;
    end
  end
`else
  logic [9:0] pub_x, pub_y, pub_w, pub_h;

  always_comb begin
    pub_x = new_x;
    pub_y = new_y;
    pub_w = new_w;
    pub_h = new_h;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt      <= 10'd0;
      y_cnt      <= 10'd0;
      min_x      <= MIN_INIT;
      min_y      <= MIN_INIT;
      max_x      <= 10'd0;
      max_y      <= 10'd0;
      cnt        <= 20'd0;
      x          <= 10'd0;
      y          <= 10'd0;
      width      <= 10'd0;
      height     <= 10'd0;
      found      <= 1'b0;
      bbox_valid <= 1'b0;
`ifdef BBOX_SMOOTH_EN
      history    <= 1'b0;
`endif
    end else begin
      bbox_valid <= 1'b0;

      if (wr_en) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= 10'd0;
          y_cnt <= (y_cnt == Y_LAST) ? 10'd0 : y_cnt + 10'd1;
        end else begin
          x_cnt <= x_cnt + 10'd1;
        end
      end

      if (eof) begin
        // Next frame's first pixel starts from clean accumulators.
        min_x      <= MIN_INIT;
        min_y      <= MIN_INIT;
        max_x      <= 10'd0;
        max_y      <= 10'd0;
        cnt        <= 20'd0;
        bbox_valid <= 1'b1;
        found      <= frame_found;
        if (frame_found) begin
          x      <= pub_x;
          y      <= pub_y;
          width  <= pub_w;
          height <= pub_h;
        end
`ifdef BBOX_SMOOTH_EN
        history <= frame_found;
`endif
      end else begin
        min_x <= mn_x;
        min_y <= mn_y;
        max_x <= mx_x;
        max_y <= mx_y;
        cnt   <= c_merged;
      end
    end
  end

endmodule
